t_ff_sequencer: RTL

- Controller that sequences a WIDTH-bit bank of T flip-flops (held internally) as a programmable modulo counter.
- Each cycle it computes the per-bit toggle-enable vector and applies Q <= Q ^ T_vec on the rising edge.
- Supports up/down counting, wrap at a programmable limit, one-shot or continuous runs, and a req/ack parallel load.
- Sits between control logic and any datapath that needs a toggle-based counter or timer.

---
 rtl/t_ff_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/t_ff_sequencer.sv
// Programmable modulo counter built on a bank of T flip-flops.
// The toggle vector is the only write path into the bank, apart from the asynchronous Clear.
module t_ff_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             mode_cont,
    input  logic [WIDTH-1:0] limit,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_val,
    output logic             load_ack,
    output logic [WIDTH-1:0] T_vec,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LOAD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic             tc_r;

    logic [WIDTH-1:0] inc_t_s;
    logic [WIDTH-1:0] dec_t_s;
    logic [WIDTH-1:0] clamp_s;
    logic [WIDTH-1:0] t_vec_s;
    logic             wrap_s;
    logic             up_carry_s;
    logic             dn_carry_s;

    // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        inc_t_s    = '0;
        dec_t_s    = '0;
        up_carry_s = 1'b1;
        dn_carry_s = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            inc_t_s[i] = up_carry_s;
            dec_t_s[i] = dn_carry_s;
            up_carry_s = up_carry_s & q_r[i];
            dn_carry_s = dn_carry_s & ~q_r[i];
        end
    end

    // Saturate the load value at the terminal value.
    always_comb begin
        if (load_val > limit) begin
            clamp_s = limit;
        end else begin
            clamp_s = load_val;
        end
    end

    // Toggle vector and wrap detection for the current state and inputs.
    always_comb begin
        t_vec_s = '0;
        wrap_s  = 1'b0;
        case (state_r)
            RUN: begin
                if (stop) begin
                    t_vec_s = '0;
                end else if (load_req) begin
                    t_vec_s = '0;
                end else if (dir) begin
                    if (q_r >= limit) begin
                        wrap_s  = 1'b1;
                        t_vec_s = q_r;
                    end else begin
                        t_vec_s = inc_t_s;
                    end
                end else begin
                    if (q_r == '0) begin
                        wrap_s  = 1'b1;
                        t_vec_s = limit;
                    end else begin
                        t_vec_s = dec_t_s;
                    end
                end
            end
            LOAD:    t_vec_s = q_r ^ clamp_s;
            default: t_vec_s = '0;
        endcase
    end

    // Sequencer state, flip-flop bank and terminal-count pulse.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_r <= IDLE;
            q_r     <= '0;
            tc_r    <= 1'b0;
        end else begin
            q_r  <= q_r ^ t_vec_s;
            tc_r <= wrap_s;
            case (state_r)
                IDLE, DONE: begin
                    if (load_req) begin
                        state_r <= LOAD;
                    end else if (start) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= state_r;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_r <= IDLE;
                    end else if (load_req) begin
                        state_r <= LOAD;
                    end else if (wrap_s && !mode_cont) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                LOAD:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign T_vec    = t_vec_s;
    assign Q        = q_r;
    assign tc       = tc_r;
    assign load_ack = (state_r == LOAD);
    assign busy     = (state_r == RUN) || (state_r == LOAD);

endmodule
